score_frame_gen: RTL and testbench
==================================

# score_frame_gen

Upstream feeder for the serial seven-segment driver. Keeps a two-digit BCD game score, composes the 64-bit active-low segment frame "ScorE-" plus two score digits, and issues one-cycle `start` requests at a fixed refresh rate. A request is issued only when the driver reports idle, and the frame is held stable until the driver finishes shifting.

## Interface
- `REFRESH_DIV`, 65536: clk cycles between refresh requests (≥4).
- `BLINK_DIV`, 16: refreshes per blink half-period (used only with the blink macro).
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `inc  in  1`: one-cycle pulse that adds 1 to the score.
- `clr  in  1`: one-cycle pulse that zeroes the score.
- `game_over  in  1`: level input; enables blinking when compiled in.
- `drv_idle  in  1`: driver finished/idle flag (its `SEG_EN`); 1 means idle.
- `frame  out  64`: segment frame. Byte 7 (`[63:56]`) is shifted out first. Active-low, bit 7 = dp.
- `start  out  1`: one-cycle load request to the driver.
- `score_bcd  out  8`: `{tens, ones}` BCD.

## Operation
- Digit codes (active-low):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Non-BCD values → C0.
  - Blank = FF.
- Frame bytes 7..0: 92 (S), A7 (c), A3 (o), AF (r), 86 (E), BF (-), seg(tens), seg(ones).
- Score update:
  - `clr` has priority over `inc`.
  - `inc` does a BCD add: ones 9 wraps to 0 and carries into tens.
  - The score saturates at 99, so `inc` at 99 has no effect.
- Refresh prescaler: counts 0..REFRESH_DIV-1 and raises `tick` for one cycle at wrap. It free-runs regardless of FSM state.
- A tick that arrives while the FSM is not in IDLE is latched as `pending`, one deep; further ticks are dropped.
- FSM states:
  - IDLE: on (`tick` or `pending`) and `drv_idle`=1, snapshot the score into `frame` and go to LOAD. If `drv_idle`=0, keep `pending` set and stay.
  - LOAD: assert `start` for exactly this cycle, clear `pending`, go to WAIT_BUSY.
  - WAIT_BUSY: wait for `drv_idle`=0, then go to WAIT_DONE. If `drv_idle` stays 1 for 4 cycles, return to IDLE (request lost; retried next tick).
  - WAIT_DONE: wait for `drv_idle`=1, then go to IDLE.
- `frame` changes only on the IDLE→LOAD transition. Score changes during a transfer appear in the next frame.

## Timing
- Reset values:
  - `score_bcd`=00.
  - `frame`={92,A7,A3,AF,86,BF,C0,C0}.
  - `start`=0, FSM=IDLE, prescaler=0, `pending`=0, blink phase=visible.
- `inc`/`clr` → `score_bcd` update: 1 cycle.
- Tick (with `drv_idle`=1) → `frame` updated the next cycle. `start` is high on the cycle after that, with `frame` already stable.
- First tick after reset: cycle REFRESH_DIV-1.
- Reset asserted mid-transfer: FSM returns to IDLE immediately and `start` drops asynchronously. The driver finishes on its own.
- `inc` and `clr` in the same cycle: result 00.

## Configuration
- `SCORE_BLINK_EN` defined:
  - While `game_over`=1, the blink phase toggles every BLINK_DIV snapshots.
  - In the blank phase, bytes 1..0 are FF. Bytes 7..2 are unchanged.
  - Phase resets to visible when `game_over`=0.
- `SCORE_BLINK_EN` undefined: `game_over` is ignored, there is no blink counter, and digits always show.

## Structure
- Shared package:
  - Segment constants (SEG_S, SEG_C, SEG_O, SEG_R, SEG_E, SEG_DASH, SEG_BLANK).
  - The digit-to-segment function.
  - FSM state encoding.
- Sub-module `bcd_score_cnt`: 2-digit saturating BCD counter with `inc`/`clr`.

## Test plan
- Reset, then 12 `inc` pulses → `score_bcd`=12. At the next snapshot, frame low bytes = F9,A4.
- Score 98, three `inc` pulses → 99 stays; frame low bytes 90,90.
- `inc`+`clr` in the same cycle at score 45 → 00.
- Hold `drv_idle`=0 across a tick, release 100 cycles later → exactly one `start` shortly after release, 2 cycles after the snapshot.
- `drv_idle` never drops after `start` → FSM back in IDLE after 4 cycles, with a new `start` on the next tick.
- With `SCORE_BLINK_EN`: `game_over`=1, BLINK_DIV=2 → low bytes alternate C0,C0 / FF,FF every 2 frames. Bytes 7..2 stay constant.

Source files
------------

// File: rtl/score_frame_gen_pkg.sv
// score_frame_gen_pkg: shared definitions for the score frame generator.
//   - active-low seven-segment codes (bit 7 = dp) for the fixed "ScorE-" text
//   - digit_seg(): BCD digit to segment code, non-BCD values show as 0
//   - state_t: refresh FSM states
package score_frame_gen_pkg;

  localparam logic [7:0] SEG_S     = 8'h92;
  localparam logic [7:0] SEG_C     = 8'hA7;
  localparam logic [7:0] SEG_O     = 8'hA3;
  localparam logic [7:0] SEG_R     = 8'hAF;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Frame bytes 7..2, byte 7 is shifted out first.
  localparam logic [47:0] FRAME_TEXT = {SEG_S, SEG_C, SEG_O, SEG_R, SEG_E, SEG_DASH};

  // Cycles WAIT_BUSY tolerates drv_idle=1 before giving up on a request.
  localparam int BUSY_TIMEOUT = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  function automatic logic [7:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    digit_seg = 8'hC0;
      4'd1:    digit_seg = 8'hF9;
      4'd2:    digit_seg = 8'hA4;
      4'd3:    digit_seg = 8'hB0;
      4'd4:    digit_seg = 8'h99;
      4'd5:    digit_seg = 8'h92;
      4'd6:    digit_seg = 8'h82;
      4'd7:    digit_seg = 8'hF8;
      4'd8:    digit_seg = 8'h80;
      4'd9:    digit_seg = 8'h90;
      default: digit_seg = 8'hC0;
    endcase
  endfunction

endpackage

// File: rtl/score_frame_gen_if.sv
// score_frame_gen_if: link between the frame generator and the serial
// seven-segment driver.
//   frame    [63:0] active-low segment frame, byte 7 shifted out first
//   start           one-cycle load request to the driver
//   drv_idle        driver idle/finished flag (1 = idle)
// master = frame generator, slave = driver.
interface score_frame_gen_if;
  logic [63:0] frame;
  logic        start;
  logic        drv_idle;

  modport master (output frame, output start, input drv_idle);
  modport slave  (input frame, input start, output drv_idle);
endinterface

// File: rtl/score_frame_gen_bcd_score_cnt.sv
// bcd_score_cnt: two-digit BCD score, saturating at 99.
//   clk, rst  clock, async active-high reset
//   inc       pulse: add one (no effect at 99)
//   clr       pulse: zero the score, wins over inc
//   score_bcd {tens, ones}
module bcd_score_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] score_bcd
);

  logic [3:0] tens;
  logic [3:0] ones;
  logic       at_max;

  assign at_max = (tens == 4'd9) && (ones == 4'd9);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (clr) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (inc && !at_max) begin
      if (ones >= 4'd9) begin
        ones <= 4'd0;
        tens <= tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

  assign score_bcd = {tens, ones};

endmodule

// File: rtl/score_frame_gen.sv
// score_frame_gen: keeps the game score, builds the "ScorE-dd" segment frame
// and requests a driver refresh every REFRESH_DIV cycles.
//   clk, rst   clock, async active-high reset
//   inc, clr   score pulses (clr wins)
//   game_over  level, enables digit blinking when SCORE_BLINK_EN is defined
//   score_bcd  current score {tens, ones}
//   drv        master side of score_frame_gen_if (frame, start, drv_idle)
// Build option: SCORE_BLINK_EN adds a blink phase that blanks the two digits
// for BLINK_DIV snapshots at a time while game_over is high.
//
// state      | meaning
// ST_IDLE    | waiting for a tick (or pending tick) with the driver idle
// ST_LOAD    | frame just captured; start goes high on the next cycle
// ST_WAIT_BUSY | waiting for the driver to go busy, gives up after 4 cycles
// ST_WAIT_DONE | driver shifting, frame held until it is idle again
module score_frame_gen
  import score_frame_gen_pkg::*;
#(
  parameter int REFRESH_DIV = 65536,
  parameter int BLINK_DIV   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              clr,
  input  logic              game_over,
  output logic [7:0]        score_bcd,
  score_frame_gen_if.master drv
);

  localparam int             PW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [1:0]     TO_LOAD  = 2'(BUSY_TIMEOUT - 1);

  state_t         state;
  state_t         state_next;
  logic [PW-1:0]  pre_cnt;
  logic           tick;
  logic           snap;
  logic           to_dec;
  logic           pending;
  logic           start_q;
  logic [1:0]     to_cnt;
  logic [63:0]    frame_q;
  logic           blank;
  logic [15:0]    digits;

  bcd_score_cnt u_score (
    .clk       (clk),
    .rst       (rst),
    .inc       (inc),
    .clr       (clr),
    .score_bcd (score_bcd)
  );

  // Free-running refresh prescaler.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + PW'(1);
  end

  assign tick = (pre_cnt == PRE_LAST);

`ifdef SCORE_BLINK_EN
  localparam int            BW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt;

  // Phase is sampled by the same snapshot that advances it, so the first
  // BLINK_DIV frames after game_over rises are still visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= BLINK_LAST;
      blank     <= 1'b0;
    end else if (!game_over) begin
      blink_cnt <= BLINK_LAST;
      blank     <= 1'b0;
    end else if (snap) begin
      if (blink_cnt == '0) begin
        blink_cnt <= BLINK_LAST;
        blank     <= ~blank;
      end else begin
        blink_cnt <= blink_cnt - BW'(1);
      end
    end
  end
`else
  logic unused_game_over;
  assign unused_game_over = game_over;
  assign blank            = 1'b0;
`endif

  assign digits = blank ? {SEG_BLANK, SEG_BLANK}
                        : {digit_seg(score_bcd[7:4]), digit_seg(score_bcd[3:0])};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    snap       = 1'b0;
    to_dec     = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((tick || pending) && drv.drv_idle) begin
          snap       = 1'b1;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_next = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!drv.drv_idle)       state_next = ST_WAIT_DONE;
        else if (to_cnt == 2'd0) state_next = ST_IDLE;
        else                     to_dec     = 1'b1;
      end
      ST_WAIT_DONE: begin
        if (drv.drv_idle) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
      pending <= 1'b0;
      to_cnt  <= 2'd0;
      frame_q <= {FRAME_TEXT, digit_seg(4'd0), digit_seg(4'd0)};
    end else begin
      start_q <= (state == ST_LOAD);
      // Any tick not consumed by a snapshot is remembered, one deep.
      if (tick && !snap)        pending <= 1'b1;
      else if (state == ST_LOAD) pending <= 1'b0;
      if (state == ST_LOAD) to_cnt <= TO_LOAD;
      else if (to_dec)      to_cnt <= to_cnt - 2'd1;
      if (snap) frame_q <= {FRAME_TEXT, digits};
    end
  end

  assign drv.start = start_q;
  assign drv.frame = frame_q;

endmodule

// File: tb/tb_score_frame_gen.sv
module tb_score_frame_gen;

  localparam int DIV  = 256;
  localparam int BDIV = 2;
  localparam logic [47:0] TEXT        = 48'h92A7A3AF86BF;
  localparam logic [63:0] RESET_FRAME = {48'h92A7A3AF86BF, 16'hC0C0};
`ifdef SCORE_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inc = 1'b0;
  logic       clr = 1'b0;
  logic       game_over = 1'b0;
  logic [7:0] score_bcd;

  score_frame_gen_if bus ();

  score_frame_gen #(.REFRESH_DIV(DIV), .BLINK_DIV(BDIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .inc       (inc),
    .clr       (clr),
    .game_over (game_over),
    .score_bcd (score_bcd),
    .drv       (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  int          mscore, s0, s1, s2, gfc, cyc;
  bit          tick_chk, force_busy, no_resp, arm, frame_moved, prev_start;
  int          busy_rem, nstarts, last_start_cyc;
  logic [63:0] prev_frame, last_start_frame;

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;  default: return 8'hC0;
    endcase
  endfunction

  function automatic logic [63:0] exp_frame(input int sc, input bit blank);
    logic [15:0] low;
    low = blank ? 16'hFFFF : {seg_of(sc / 10), seg_of(sc % 10)};
    return {TEXT, low};
  endfunction

  function automatic logic [7:0] bcd_of(input int sc);
    return {4'(sc / 10), 4'(sc % 10)};
  endfunction

  task automatic do_reset();
    rst = 1'b1; inc = 1'b0; clr = 1'b0; game_over = 1'b0;
    bus.drv_idle = 1'b1;
    force_busy = 0; no_resp = 0; tick_chk = 0; arm = 0; busy_rem = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0; mscore = 0; s0 = 0; s1 = 0; s2 = 0; gfc = 0;
    prev_frame = RESET_FRAME; frame_moved = 0; prev_start = 0;
    nstarts = 0; last_start_cyc = -1;
  endtask

  // One clock: drive inputs, advance model, check outputs #1 after the edge,
  // then update the driver model for the next cycle.
  task automatic step(input bit i_inc, input bit i_clr);
    bit exp_start;
    bit blank;
    inc = i_inc; clr = i_clr;
    @(posedge clk);
    if (i_clr) mscore = 0;
    else if (i_inc && mscore < 99) mscore++;
    #1;
    inc = 1'b0; clr = 1'b0;
    cyc++;
    s2 = s1; s1 = s0; s0 = mscore;

    checks++;
    if (score_bcd !== bcd_of(mscore)) begin
      errors++;
      $display("FAIL score_bcd @%0d: got %h want %h", cyc, score_bcd, bcd_of(mscore));
    end
    if (frame_moved) begin
      checks++;
      if (bus.start !== 1'b1) begin
        errors++;
        $display("FAIL frame_change_without_start @%0d: start got %b want 1", cyc, bus.start);
      end
    end
    frame_moved = (bus.frame !== prev_frame);
    prev_frame  = bus.frame;
    if (tick_chk) begin
      exp_start = (cyc >= DIV + 1) && (((cyc - DIV - 1) % DIV) == 0);
      checks++;
      if (bus.start !== exp_start) begin
        errors++;
        $display("FAIL start_timing @%0d: got %b want %b", cyc, bus.start, exp_start);
      end
    end
    if (bus.start === 1'b1) begin
      nstarts++;
      last_start_cyc   = cyc;
      last_start_frame = bus.frame;
      checks++;
      if (prev_start) begin
        errors++;
        $display("FAIL start_width @%0d: got 2+ cycles want 1", cyc);
      end
      if (BLINK_EN && game_over) begin
        blank = ((gfc / BDIV) % 2) == 1;
        gfc++;
      end else begin
        blank = 0;
        gfc = 0;
      end
      checks++;
      if (bus.frame !== exp_frame(s2, blank)) begin
        errors++;
        $display("FAIL frame @%0d: got %h want %h", cyc, bus.frame, exp_frame(s2, blank));
      end
    end
    prev_start = bus.start;

    if (force_busy)               bus.drv_idle = 1'b0;
    else if (no_resp)             bus.drv_idle = 1'b1;
    else if (bus.start === 1'b1) begin arm = 1; bus.drv_idle = 1'b1; end
    else if (arm) begin
      arm = 0;
      busy_rem = $urandom_range(39, 0);
      bus.drv_idle = 1'b0;
    end else if (busy_rem > 0) begin
      busy_rem--;
      bus.drv_idle = 1'b0;
    end else                      bus.drv_idle = 1'b1;
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    step(0, 0);
    while (bus.start !== 1'b1 && n < 2 * DIV) begin
      step(0, 0);
      n++;
    end
    checks++;
    if (bus.start !== 1'b1) begin
      errors++;
      $display("FAIL %s: start got %b want 1 within %0d cycles", tag, bus.start, 2 * DIV);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 3;
    if (score_bcd !== 8'h00) begin errors++; $display("FAIL reset_score: got %h want 00", score_bcd); end
    if (bus.frame !== RESET_FRAME) begin errors++; $display("FAIL reset_frame: got %h want %h", bus.frame, RESET_FRAME); end
    if (bus.start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", bus.start); end
    tick_chk = 1;
    repeat (DIV + 4) step(0, 0);
    checks++;
    if (nstarts != 1 || last_start_cyc != DIV + 1) begin
      errors++;
      $display("FAIL first_tick: got %0d starts last@%0d want 1 @%0d", nstarts, last_start_cyc, DIV + 1);
    end
  endtask

  task automatic test_count_12();
    do_reset();
    tick_chk = 1;
    repeat (12) begin step(1, 0); step(0, 0); end
    checks++;
    if (score_bcd !== 8'h12) begin errors++; $display("FAIL count_12: got %h want 12", score_bcd); end
    wait_start("count_12_start");
    checks++;
    if (last_start_frame[15:0] !== 16'hF9A4) begin
      errors++; $display("FAIL count_12_frame: got %h want F9A4", last_start_frame[15:0]);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    tick_chk = 1;
    repeat (98) begin step(1, 0); step(0, 0); end
    checks++;
    if (score_bcd !== 8'h98) begin errors++; $display("FAIL sat_98: got %h want 98", score_bcd); end
    repeat (3) begin step(1, 0); step(0, 0); end
    checks++;
    if (score_bcd !== 8'h99) begin errors++; $display("FAIL sat_99: got %h want 99", score_bcd); end
    wait_start("sat_start");
    checks++;
    if (last_start_frame[15:0] !== 16'h9090) begin
      errors++; $display("FAIL sat_frame: got %h want 9090", last_start_frame[15:0]);
    end
  endtask

  task automatic test_inc_clr();
    do_reset();
    repeat (45) step(1, 0);
    checks++;
    if (score_bcd !== 8'h45) begin errors++; $display("FAIL pre_clr: got %h want 45", score_bcd); end
    step(1, 1);
    checks++;
    if (score_bcd !== 8'h00) begin errors++; $display("FAIL inc_clr: got %h want 00", score_bcd); end
  endtask

  task automatic test_pending();
    int rel;
    do_reset();
    force_busy = 1;
    bus.drv_idle = 1'b0;
    while (cyc < 300) step(0, 0);
    repeat (7) step(1, 0);
    while (cyc < DIV + 99) step(0, 0);
    force_busy = 0;
    bus.drv_idle = 1'b1;
    rel = cyc;
    repeat (15) step(0, 0);
    checks++;
    if (nstarts != 1 || last_start_cyc != rel + 2) begin
      errors++;
      $display("FAIL pending: got %0d starts last@%0d want 1 @%0d", nstarts, last_start_cyc, rel + 2);
    end
    checks++;
    if (last_start_frame[15:0] !== 16'hC0F8) begin
      errors++; $display("FAIL pending_frame: got %h want C0F8", last_start_frame[15:0]);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    no_resp = 1;
    tick_chk = 1;
    repeat (3 * DIV + 10) step(0, 0);
    checks++;
    if (nstarts != 3) begin errors++; $display("FAIL timeout_retry: got %0d starts want 3", nstarts); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wait_start("mid_start");
    rst = 1'b1;
    #1;
    checks += 3;
    if (bus.start !== 1'b0) begin errors++; $display("FAIL mid_reset_start: got %b want 0", bus.start); end
    if (bus.frame !== RESET_FRAME) begin errors++; $display("FAIL mid_reset_frame: got %h want %h", bus.frame, RESET_FRAME); end
    if (score_bcd !== 8'h00) begin errors++; $display("FAIL mid_reset_score: got %h want 00", score_bcd); end
  endtask

  task automatic test_random();
    int want;
    do_reset();
    tick_chk = 1;
    repeat (5 * DIV) step($urandom_range(7, 0) == 0, $urandom_range(63, 0) == 0);
    want = (5 * DIV - (DIV + 1)) / DIV + 1;
    checks++;
    if (nstarts != want) begin errors++; $display("FAIL random_starts: got %0d want %0d", nstarts, want); end
  endtask

`ifdef SCORE_BLINK_EN
  task automatic test_blink();
    logic [15:0] want;
    do_reset();
    game_over = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_start("blink_start");
      want = (((k / BDIV) % 2) == 1) ? 16'hFFFF : 16'hC0C0;
      checks += 2;
      if (last_start_frame[15:0] !== want) begin
        errors++; $display("FAIL blink_low[%0d]: got %h want %h", k, last_start_frame[15:0], want);
      end
      if (last_start_frame[63:16] !== TEXT) begin
        errors++; $display("FAIL blink_text[%0d]: got %h want %h", k, last_start_frame[63:16], TEXT);
      end
    end
    game_over = 1'b0;
    wait_start("blink_off_start");
    checks++;
    if (last_start_frame[15:0] !== 16'hC0C0) begin
      errors++; $display("FAIL blink_off: got %h want C0C0", last_start_frame[15:0]);
    end
  endtask
`else
  task automatic test_game_over_ignored();
    do_reset();
    game_over = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_start("go_start");
      checks++;
      if (last_start_frame !== RESET_FRAME) begin
        errors++; $display("FAIL game_over_ignored[%0d]: got %h want %h", k, last_start_frame, RESET_FRAME);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_count_12();
    test_saturate();
    test_inc_clr();
    test_pending();
    test_timeout();
    test_reset_mid();
    test_random();
`ifdef SCORE_BLINK_EN
    test_blink();
`else
    test_game_over_ignored();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
